// File: rtl/audio_buffer_mp_ctrl.sv
// -----------------------------------------------------------------------------
// audio_buffer_mp_ctrl
//
// Single-port PCM word buffer shared by NUM_CLIENTS codec engines through a
// round-robin arbiter. A client may lock the grant to run a burst. An owner
// that goes quiet for LOCK_TIMEOUT cycles loses the lock and lock_timeout
// pulses. Reads return data exactly one cycle after accept, tagged by a
// per-client rsp_valid pulse. Out-of-range accesses are still accepted and
// counted. They never touch memory, return zero data on reads, and pulse
// addr_err.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-client request valid
//   req_wen       per-client 1 = write, 0 = read
//   req_lock      per-client: keep the grant after this transaction
//   req_addr      packed word addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata     packed write data, client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_be        packed byte enables, client i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
//   req_ready     grant, one-hot or zero (combinational)
//   rsp_valid     one-cycle read-response pulse to the issuing client
//   rsp_rdata     read data, shared, held until the next read response
//   addr_err      one-cycle pulse after an accepted access with addr >= DEPTH
//   lock_timeout  one-cycle pulse when an idle lock is forcibly released
//   rd_count      accepted reads, saturating at all-ones
//   wr_count      accepted writes, saturating at all-ones
// -----------------------------------------------------------------------------
module audio_buffer_mp_ctrl #(
  parameter int NUM_CLIENTS  = 3,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4096,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req_valid,
  input  logic [NUM_CLIENTS-1:0]            req_wen,
  input  logic [NUM_CLIENTS-1:0]            req_lock,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_CLIENTS*DATA_WIDTH/8-1:0] req_be,
  output logic [NUM_CLIENTS-1:0]            req_ready,
  output logic [NUM_CLIENTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              addr_err,
  output logic                              lock_timeout,
  output logic [31:0]                       rd_count,
  output logic [31:0]                       wr_count
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(NUM_CLIENTS);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDLE_W = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_W    = DEPTH[ADDR_WIDTH:0];
  localparam logic [IDLE_W-1:0]   IDLE_LIMIT = IDLE_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {ARB, LOCKED} state_t;
  typedef logic [PTR_W-1:0] id_t;

  localparam id_t LAST_ID = PTR_W'(NUM_CLIENTS - 1);

  // Cyclic successor of a client index.
  function automatic id_t next_id(input id_t id);
    return (id == LAST_ID) ? '0 : id + id_t'(1);
  endfunction

  state_t            state, state_next;
  id_t               rr_ptr, owner, winner, acc_id;
  logic              found, accept, timeout_hit, in_range;
  logic [IDLE_W-1:0] idle_cnt;

  // ---------------------------------------------------------------------------
  // Per-client views of the packed request buses.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CLIENTS];
  logic [BYTES-1:0]      be_arr    [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = req_be[g*BYTES +: BYTES];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid client starting at rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    id_t cand;
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it holding a value and a latch is never inferred.
    winner = '0;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = next_id(cand);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (rst) begin
      state        <= ARB;
      rr_ptr       <= '0;
      owner        <= '0;
      idle_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      lock_timeout <= timeout_hit;

      if (accept)
        rr_ptr <= next_id(acc_id);
      else if (timeout_hit)
        rr_ptr <= next_id(owner);

      if (state == ARB && accept && req_lock[acc_id])
        owner <= acc_id;

      // Idle cycles only accumulate while a lock is held and the owner is quiet.
      if (accept || timeout_hit || state != LOCKED)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      ARB: begin
        if (accept && req_lock[acc_id])
          state_next = LOCKED;
      end
      LOCKED: begin
        if (accept) begin
          if (!req_lock[owner])
            state_next = ARB;
        end else if (idle_cnt == IDLE_LIMIT) begin
          timeout_hit = 1'b1;
          state_next  = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. While locked the owner holds ready even when it is idle, so
  // it can resume its burst at any time; everyone else stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state == LOCKED)
        req_ready[owner] = 1'b1;
      else if (found)
        req_ready[winner] = 1'b1;
    end
  end

  assign acc_id   = (state == LOCKED) ? owner : winner;
  assign accept   = |(req_ready & req_valid);
  assign in_range = {1'b0, addr_arr[acc_id]} < DEPTH_W;

  // ---------------------------------------------------------------------------
  // Storage with byte-enable writes.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      mem_idx;

  assign mem_idx = addr_arr[acc_id][IDX_W-1:0];

  // NOTE: the array has no reset branch; clearing it would turn the SRAM into
  // flops, and software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    if (accept && req_wen[acc_id] && in_range) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be_arr[acc_id][k])
          mem[mem_idx][k*8 +: 8] <= wdata_arr[acc_id][k*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read response, error flag and access counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      addr_err  <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      rsp_valid <= '0;
      addr_err  <= 1'b0;
      if (accept) begin
        addr_err <= !in_range;
        if (req_wen[acc_id]) begin
          if (wr_count != '1)
            wr_count <= wr_count + 32'd1;
        end else begin
          rsp_valid[acc_id] <= 1'b1;
          rsp_rdata         <= in_range ? mem[mem_idx] : '0;
          if (rd_count != '1)
            rd_count <= rd_count + 32'd1;
        end
      end
    end
  end

endmodule
